// File: rtl/pts_sr_16_if.sv
// Block-load / word-serial handshake bundle for pts_sr_16.
// The master loads blocks and consumes words; the slave is the shift register itself.
interface pts_sr_16_if #(
    parameter int NUM_WORDS = 16,
    parameter int WORD_W    = 32
);
    localparam int CNT_W = $clog2(NUM_WORDS);

    logic                        clear;
    logic                        load;
    logic [NUM_WORDS*WORD_W-1:0] parallel_in;
    logic                        load_ready;
    logic [WORD_W-1:0]           serial_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        last;
    logic [CNT_W-1:0]            word_cnt;
    logic                        done;

    modport master (
        output clear, load, parallel_in, out_ready,
        input  load_ready, serial_out, out_valid, last, word_cnt, done
    );

    modport slave (
        input  clear, load, parallel_in, out_ready,
        output load_ready, serial_out, out_valid, last, word_cnt, done
    );
endinterface

// File: rtl/pts_sr_16.sv
// Parallel-to-serial shift register: captures a whole block in one cycle and
// emits it most-significant word first over a valid/ready handshake.
module pts_sr_16 #(
    parameter int NUM_WORDS = 16,
    parameter int WORD_W    = 32
) (
    input  logic         clk,
    input  logic         n_rst,
    pts_sr_16_if.slave   bus
);
    localparam int BLK_W = NUM_WORDS * WORD_W;
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [BLK_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (bus.clear) begin
            // Flush wins over load and over a coinciding transfer.
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        state_d = SEND;
                        shift_d = bus.parallel_in;
                        cnt_d   = '0;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        // Zero fill leaves the register cleared once the last word leaves.
                        shift_d = {shift_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                        if (cnt_q == LAST_IDX) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the wide shift register is reset too, so serial_out reads 0 rather than X in IDLE.
    // NOTE: sequential state is updated with <= only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.out_valid  = (state_q == SEND);
    assign bus.last       = (state_q == SEND) && (cnt_q == LAST_IDX);
    assign bus.serial_out = shift_q[BLK_W-1 -: WORD_W];
    assign bus.word_cnt   = cnt_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_pts_sr_16.sv
// Randomised scoreboard bench for pts_sr_16: a block-level model queues the
// expected words on every accepted load, a negedge monitor checks the DUT outputs.
module tb_pts_sr_16;
    localparam int NW = 16;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    pts_sr_16_if #(.NUM_WORDS(NW), .WORD_W(WW)) bus ();

    pts_sr_16 #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: block-level view, words remaining and a pending done flag.
    logic [WW-1:0] exp_q[$];
    int            m_remaining;
    logic          m_done;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_remaining = 0;
            m_done      = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (bus.clear) begin
                m_remaining = 0;
                exp_q.delete();
            end else if (m_remaining == 0) begin
                if (bus.load) begin
                    for (int k = 0; k < NW; k++)
                        exp_q.push_back(bus.parallel_in[WW*(NW-k)-1 -: WW]);
                    m_remaining = NW;
                end
            end else if (bus.out_ready) begin
                m_remaining--;
                if (m_remaining == 0) m_done = 1'b1;
            end
        end
    end

    // Monitor: compares everything the DUT shows, pops a word on each real transfer.
    always @(negedge clk) begin
        if (n_rst) begin
            logic [WW-1:0] exp_word;
            exp_word = (m_remaining == 0) ? '0 :
                       (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
            check("out_valid",  32'(bus.out_valid),  32'(m_remaining != 0));
            check("load_ready", 32'(bus.load_ready), 32'(m_remaining == 0));
            check("done",       32'(bus.done),       32'(m_done));
            check("last",       32'(bus.last),       32'(m_remaining == 1));
            check("word_cnt",   32'(bus.word_cnt),   32'((m_remaining == 0) ? 0 : NW - m_remaining));
            check("serial_out", bus.serial_out,      exp_word);
            if (bus.out_valid && bus.out_ready && !bus.clear && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
    end

    function automatic logic [NW*WW-1:0] rand_blk();
        logic [NW*WW-1:0] b;
        for (int i = 0; i < NW; i++) b[WW*i +: WW] = $urandom;
        return b;
    endfunction

    task automatic drive(input logic ld, input logic rdy, input logic clr, input logic [NW*WW-1:0] d);
        bus.load        = ld;
        bus.out_ready   = rdy;
        bus.clear       = clr;
        bus.parallel_in = d;
        @(posedge clk);
        #1;
    endtask

    logic [NW*WW-1:0] ramp;

    initial begin
        n_rst           = 1'b0;
        bus.load        = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clear       = 1'b0;
        bus.parallel_in = '0;
        for (int i = 0; i < NW; i++) ramp[WW*i +: WW] = i;

        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);

        // Ramp block streamed at full rate.
        drive(1'b1, 1'b1, 1'b0, ramp);
        repeat (20) drive(1'b0, 1'b1, 1'b0, rand_blk());

        // Same block under a 1,0,0,1 ready pattern.
        drive(1'b1, 1'b1, 1'b0, ramp);
        for (int c = 1; c < 45; c++)
            drive(1'b0, (c % 4 == 0) || (c % 4 == 3), 1'b0, '0);

        // Load requests in the middle of a block are ignored.
        drive(1'b1, 1'b1, 1'b0, ramp);
        for (int c = 1; c < 20; c++)
            drive((c >= 5 && c <= 7), 1'b1, 1'b0, rand_blk());

        // clear together with load during word 7, then a fresh block.
        drive(1'b1, 1'b1, 1'b0, rand_blk());
        for (int c = 1; c < 7; c++) drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, rand_blk());
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, rand_blk());
        repeat (20) drive(1'b0, 1'b1, 1'b0, '0);

        // Load held high: blocks go back to back, each taken in the done cycle.
        repeat (3 * (NW + 1) + 2) drive(1'b1, 1'b1, 1'b0, rand_blk());
        repeat (20) drive(1'b0, 1'b1, 1'b0, '0);

        // Random traffic with occasional flushes.
        repeat (3000)
            drive(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 64) == 0, rand_blk());
        repeat (40) drive(1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset in the middle of a block, checked before any clock edge.
        drive(1'b1, 1'b1, 1'b0, ramp);
        repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
        #1 n_rst = 1'b0;
        #1;
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_serial_out", bus.serial_out,      32'd0);
        check("rst_word_cnt",   32'(bus.word_cnt),   32'd0);
        check("rst_last",       32'(bus.last),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        // A fresh block after reset streams from word 0.
        drive(1'b1, 1'b1, 1'b0, rand_blk());
        repeat (20) drive(1'b0, 1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
